// File: rtl/multicycle_core_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_core_ctrl_pkg
//   Shared definitions for the multi-cycle core sequencer: the sequencer state
//   type, default address width and reset PC, and the mask used to detect a
//   misaligned next PC (instructions are 32-bit and word aligned).
// ----------------------------------------------------------------------------
package multicycle_core_ctrl_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Any set bit under this mask in a next-PC value is a misaligned target.
  localparam logic [1:0]  PC_ALIGN_MASK    = 2'b11;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    WB,
    HALT,
    ERROR
  } state_e;

endpackage

// File: rtl/multicycle_core_ctrl_wait_timeout_timer.sv
// ----------------------------------------------------------------------------
// wait_timeout_timer
//   Counts cycles spent in a wait state and flags the cycle in which the
//   TIMEOUT-th consecutive wait cycle elapses without the wait being resolved.
//   TIMEOUT = 0 disables the timer entirely.
//
// Ports:
//   clk     in   core clock
//   rst     in   synchronous, active-high reset
//   clear   in   restart the count (asserted whenever not waiting)
//   enable  in   count this cycle
//   expired out  this is the TIMEOUT-th enabled cycle since the last clear
// ----------------------------------------------------------------------------
module wait_timeout_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The count only has to reach TIMEOUT-1, since expiry fires in that cycle.
  localparam int unsigned    CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  assign expired = (TIMEOUT != 0) && enable && (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_core_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_core_ctrl
//   Multi-cycle sequencer for the core. Owns PC and instruction register and
//   steps fetch -> execute -> (memory) -> writeback through valid/ready
//   handshakes to variable-latency instruction and data memories. Reports
//   commits, counts cycles and retired instructions, halts on ebreak and
//   traps to a terminal error state on wait timeout or misaligned next PC.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr      fetch request (address = pc)
//   imem_rsp_valid/data                  fetch response
//   dmem_req_valid/ready, dmem_rsp_valid load/store request and completion
//   dec_mem_read/write, dec_reg_write, dec_ebreak  decode of inst_q (EXEC/WB)
//   exu_pc_next                    next PC from the execute unit
//   pc, inst_q                     architectural PC, latched instruction
//   rf_wen                         register-file write enable (WB only)
//   commit_valid/pc/pc_next        one-cycle retire report
//   halted, err                    sticky terminal status
//   cycle_cnt, instret_cnt         performance counters (wrap)
// ----------------------------------------------------------------------------
module multicycle_core_ctrl
  import multicycle_core_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     CNT_W    = 64,
  parameter int unsigned     TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  input  logic             dmem_rsp_valid,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_reg_write,
  input  logic             dec_ebreak,
  input  logic [XLEN-1:0]  exu_pc_next,
  output logic [XLEN-1:0]  pc,
  output logic [31:0]      inst_q,
  output logic             rf_wen,
  output logic             commit_valid,
  output logic [XLEN-1:0]  commit_pc,
  output logic [XLEN-1:0]  commit_pc_next,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      inst_d;
  logic [CNT_W-1:0] cycle_q, instret_q;

  logic in_wait, terminal, misaligned, wait_expired;
  logic imem_req_c, dmem_req_c, rf_wen_c, commit_c;

  assign in_wait    = (state_q == FETCH_WAIT) || (state_q == MEM_WAIT);
  assign terminal   = (state_q == HALT) || (state_q == ERROR);
  assign misaligned = |(exu_pc_next[1:0] & PC_ALIGN_MASK);

  // One timer serves both wait states; it restarts whenever we are not
  // waiting, and a wait state is always entered from a non-wait state.
  wait_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (wait_expired)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    rf_wen_c   = 1'b0;
    commit_c   = 1'b0;

    unique case (state_q)
      FETCH_REQ: begin
        imem_req_c = 1'b1;
        if (imem_req_ready) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        // A response in the expiring cycle still wins over the timeout.
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = EXEC;
        end else if (wait_expired) begin
          state_d = ERROR;
        end
      end
      EXEC: begin
        // ebreak retires in place; the PC is left pointing at it.
        if (dec_ebreak) begin
          commit_c = 1'b1;
          state_d  = HALT;
        end else if (dec_mem_read || dec_mem_write) begin
          state_d = MEM_REQ;
        end else begin
          state_d = WB;
        end
      end
      MEM_REQ: begin
        dmem_req_c = 1'b1;
        if (dmem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d = WB;
        end else if (wait_expired) begin
          state_d = ERROR;
        end
      end
      WB: begin
        if (misaligned) begin
          state_d = ERROR;
        end else begin
          rf_wen_c = dec_reg_write;
          commit_c = 1'b1;
          pc_d     = exu_pc_next;
          state_d  = FETCH_REQ;
        end
      end
      HALT, ERROR: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      if (!terminal) cycle_q   <= cycle_q + CNT_W'(1);
      if (commit_c)  instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Requests and pulses are suppressed in the cycle reset is taken, so a
  // handshake can never complete against a state that is being discarded.
  assign imem_req_valid = imem_req_c & ~rst;
  assign dmem_req_valid = dmem_req_c & ~rst;
  assign rf_wen         = rf_wen_c   & ~rst;
  assign commit_valid   = commit_c   & ~rst;

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign commit_pc      = pc_q;
  assign commit_pc_next = exu_pc_next;
  assign halted         = (state_q == HALT);
  assign err            = (state_q == ERROR);
  assign cycle_cnt      = cycle_q;
  assign instret_cnt    = instret_q;

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_core_ctrl
//   Drives the sequencer as its memories and decoder would, with randomized
//   handshake latencies and noise on handshake inputs outside the windows in
//   which they matter. Expected behaviour comes from a per-instruction phase
//   schedule (durations of request/wait phases) and a PC/instret/cycle model.
//   A second instance with TIMEOUT = 0 shares the stimulus.
// ----------------------------------------------------------------------------
module tb_multicycle_core_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int unsigned TMO    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
  logic        dec_mem_read = 1'b0, dec_mem_write = 1'b0;
  logic        dec_reg_write = 1'b0, dec_ebreak = 1'b0;
  logic [31:0] exu_pc_next = '0;

  logic        imem_req_valid, dmem_req_valid, rf_wen, commit_valid, halted, err;
  logic [31:0] imem_addr, pc, inst_q, commit_pc, commit_pc_next;
  logic [63:0] cycle_cnt, instret_cnt;

  logic        nt_imem_req_valid, nt_dmem_req_valid, nt_rf_wen, nt_commit_valid;
  logic        nt_halted, nt_err;
  logic [31:0] nt_imem_addr, nt_pc, nt_inst_q, nt_commit_pc, nt_commit_pc_next;
  logic [63:0] nt_cycle_cnt, nt_instret_cnt;

  always #5 clk = ~clk;

  multicycle_core_ctrl #(.TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_rsp_valid(dmem_rsp_valid),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .dec_ebreak(dec_ebreak), .exu_pc_next(exu_pc_next),
    .pc(pc), .inst_q(inst_q), .rf_wen(rf_wen),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_pc_next(commit_pc_next),
    .halted(halted), .err(err), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  multicycle_core_ctrl #(.TIMEOUT(0)) u_dut_nt (
    .clk(clk), .rst(rst),
    .imem_req_valid(nt_imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(nt_imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dmem_req_valid(nt_dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_rsp_valid(dmem_rsp_valid),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .dec_ebreak(dec_ebreak), .exu_pc_next(exu_pc_next),
    .pc(nt_pc), .inst_q(nt_inst_q), .rf_wen(nt_rf_wen),
    .commit_valid(nt_commit_valid), .commit_pc(nt_commit_pc),
    .commit_pc_next(nt_commit_pc_next),
    .halted(nt_halted), .err(nt_err), .cycle_cnt(nt_cycle_cnt), .instret_cnt(nt_instret_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural PC and counters after each instruction.
  logic [31:0] m_pc;
  logic [63:0] m_instret, m_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_reg_write = 1'b0; dec_ebreak = 1'b0;
    exu_pc_next = '0;
  endtask

  task automatic do_reset(input bit with_checks);
    rst = 1'b1;
    idle_inputs();
    cyc();
    @(negedge clk);
    if (with_checks) begin
      check("rst_pc", pc, RST_PC);
      check("rst_inst_q", inst_q, 0);
      check("rst_cycle", cycle_cnt, 0);
      check("rst_instret", instret_cnt, 0);
      check("rst_halted", halted, 0);
      check("rst_err", err, 0);
      check("rst_imem_req", imem_req_valid, 0);
      check("rst_dmem_req", dmem_req_valid, 0);
      check("rst_commit", commit_valid, 0);
      check("rst_rf_wen", rf_wen, 0);
    end
    cyc();
    rst = 1'b0;
    m_pc = RST_PC; m_instret = 0; m_cycles = 0;
  endtask

  // One instruction. kind: 0 = ALU, 1 = load, 2 = store. Latencies:
  //   ird  cycles imem_req_ready is held low before acceptance
  //   rspd cycles in FETCH_WAIT before the response cycle
  //   dd   cycles dmem_req_ready is held low before acceptance
  //   dr   cycles in MEM_WAIT before the response cycle
  task automatic run_instr(input int kind, input bit rw, input int ird, input int rspd,
                           input int dd, input int dr, input logic [31:0] pc_next,
                           input logic [31:0] word);
    bit is_mem;
    int t_fw, t_ex, t_mr, t_mw, t_wb;
    is_mem = (kind != 0);
    t_fw = ird + 1;
    t_ex = t_fw + rspd + 1;
    t_mr = t_ex + 1;
    t_mw = t_mr + dd + 1;
    t_wb = is_mem ? t_mw + dr + 1 : t_ex + 1;
    dec_mem_read  = (kind == 1);
    dec_mem_write = (kind == 2);
    dec_reg_write = rw;
    dec_ebreak    = 1'b0;
    exu_pc_next   = pc_next;
    for (int c = 0; c <= t_wb; c++) begin
      imem_req_ready = (c < t_fw) ? (c == ird) : noise();
      imem_rsp_valid = (c >= t_fw && c < t_ex) ? (c == t_ex - 1) : noise();
      imem_rsp_data  = (c == t_ex - 1) ? word : $urandom;
      dmem_req_ready = (is_mem && c >= t_mr && c < t_mw) ? (c == t_mw - 1) : noise();
      dmem_rsp_valid = (is_mem && c >= t_mw && c < t_wb) ? (c == t_wb - 1) : noise();
      @(negedge clk);
      check("imem_req_valid", imem_req_valid, c < t_fw);
      if (c < t_fw) check("imem_addr", imem_addr, m_pc);
      check("dmem_req_valid", dmem_req_valid, is_mem && c >= t_mr && c < t_mw);
      check("commit_valid", commit_valid, c == t_wb);
      check("rf_wen", rf_wen, c == t_wb && rw);
      if (c == t_wb) begin
        check("commit_pc", commit_pc, m_pc);
        check("commit_pc_next", commit_pc_next, pc_next);
      end
      cyc();
    end
    m_pc      = pc_next;
    m_instret = m_instret + 1;
    m_cycles  = m_cycles + 64'(t_wb + 1);
    check("pc", pc, m_pc);
    check("instret", instret_cnt, m_instret);
    check("cycle_cnt", cycle_cnt, m_cycles);
    check("inst_q", inst_q, word);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, nxt;
    int kind;
    bit saw_commit;
    logic [63:0] c0;

    #1;
    do_reset(1'b1);

    // ALU at reset PC, zero-wait: four cycles.
    run_instr(0, 1'b1, 0, 0, 0, 0, 32'h8000_0004, 32'h0010_0093);
    check("addi_cycles", cycle_cnt, 4);
    check("addi_pc", pc, 32'h8000_0004);

    // Zero-wait load: six cycles.
    c0 = m_cycles;
    run_instr(1, 1'b1, 0, 0, 0, 0, 32'h8000_0008, 32'h0000_2103);
    check("load0_cycles", cycle_cnt - c0, 6);

    // Load with ready delayed 3 cycles and response 2 cycles after accept.
    c0 = m_cycles;
    run_instr(1, 1'b1, 0, 0, 3, 1, 32'h8000_000c, 32'h0040_2183);
    check("load_slow_cycles", cycle_cnt - c0, 10);
    check("load_slow_instret", instret_cnt, 3);

    // Responses in the last permitted wait cycle do not time out.
    run_instr(0, 1'b0, 2, TMO - 1, 0, 0, 32'h8000_0010, 32'h1234_5013);
    run_instr(2, 1'b0, 0, 0, 1, TMO - 1, 32'h8000_0014, 32'h00a1_2023);
    check("edge_err", err, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      w = $urandom;
      nxt = (i % 3 == 0) ? ($urandom & 32'hffff_fffc) : m_pc + 32'd4;
      run_instr(kind, (kind == 2) ? 1'b0 : noise(), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3), nxt, w);
    end
    check("rand_err", err, 0);

    // Reset during MEM_WAIT, then a stale dmem response after release.
    do_reset(1'b0);
    dec_mem_read = 1'b1; dec_reg_write = 1'b1; exu_pc_next = 32'h8000_0004;
    imem_req_ready = 1'b1; cyc();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_2083; cyc();
    imem_rsp_valid = 1'b0; cyc();
    dmem_req_ready = 1'b1; cyc();
    dmem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mrst_dmem_req", dmem_req_valid, 0);
    cyc();
    rst = 1'b0; dmem_rsp_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("mrst_pc", pc, RST_PC);
      check("mrst_cycle", cycle_cnt, 64'(c));
      check("mrst_instret", instret_cnt, 0);
      check("mrst_fetch_req", imem_req_valid, 1);
      check("mrst_dmem_req2", dmem_req_valid, 0);
      check("mrst_commit", commit_valid, 0);
      cyc();
    end
    dmem_rsp_valid = 1'b0;
    m_pc = RST_PC; m_instret = 0; m_cycles = 2;
    run_instr(0, 1'b1, 0, 1, 0, 0, 32'h8000_0004, 32'h0050_0113);

    // Misaligned next PC in WB traps without committing.
    do_reset(1'b0);
    dec_reg_write = 1'b1; exu_pc_next = 32'h8000_0006;
    imem_req_ready = 1'b1; cyc();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0067; cyc();
    imem_rsp_valid = 1'b0; cyc();
    @(negedge clk);
    check("mis_rf_wen", rf_wen, 0);
    check("mis_commit", commit_valid, 0);
    cyc();
    @(negedge clk);
    check("mis_err", err, 1);
    check("mis_pc", pc, RST_PC);
    check("mis_instret", instret_cnt, 0);
    check("mis_cycle", cycle_cnt, 4);
    check("mis_imem_req", imem_req_valid, 0);

    // ebreak: retires in EXEC, then halts with frozen counters.
    do_reset(1'b0);
    dec_ebreak = 1'b1; dec_mem_read = 1'b1; exu_pc_next = 32'h8000_0004;
    imem_req_ready = 1'b1; cyc();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073; cyc();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    check("ebreak_commit", commit_valid, 1);
    check("ebreak_commit_pc", commit_pc, RST_PC);
    check("ebreak_halted_early", halted, 0);
    cyc();
    saw_commit = 1'b0;
    for (int c = 0; c < 21; c++) begin
      imem_req_ready = noise(); imem_rsp_valid = noise();
      dmem_req_ready = noise(); dmem_rsp_valid = noise();
      @(negedge clk);
      if (c == 0) check("ebreak_halted", halted, 1);
      check("halt_imem_req", imem_req_valid, 0);
      check("halt_dmem_req", dmem_req_valid, 0);
      if (commit_valid) saw_commit = 1'b1;
      cyc();
    end
    check("halt_no_commit", saw_commit, 0);
    check("halt_cycle", cycle_cnt, 3);
    check("halt_instret", instret_cnt, 1);
    check("halt_sticky", halted, 1);

    // imem never responds: TIMEOUT=8 traps, TIMEOUT=0 keeps waiting.
    do_reset(1'b0);
    imem_req_ready = 1'b1; cyc();
    imem_req_ready = 1'b0;
    saw_commit = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      check("tmo_err_early", err, 0);
      cyc();
    end
    for (int c = 0; c < 2000; c++) begin
      imem_req_ready = noise();
      @(negedge clk);
      if (c == 0) check("tmo_err", err, 1);
      if (commit_valid || nt_commit_valid) saw_commit = 1'b1;
      cyc();
    end
    check("tmo_no_commit", saw_commit, 0);
    check("tmo_cycle", cycle_cnt, 1 + TMO);
    check("tmo_err_sticky", err, 1);
    check("tmo0_err", nt_err, 0);
    check("tmo0_no_req", nt_imem_req_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_core_ctrl.md
Name: multicycle_core_ctrl

Overview:
- Parametrised multi-cycle sequencer that replaces the single-cycle core's implicit every-clock PC/fetch/writeback flow.
- Owns the PC and instruction registers.
- Sequences fetch, execute, memory and writeback through explicit valid/ready handshakes to instruction and data memory, which may have variable latency.
- Provides commit reporting (for DPI difftest), performance counters, halt on ebreak, and bus-timeout/misalignment error detection.
- Sits in the core top, between the memory interfaces and the existing decode/execute/register-file datapath.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- CNT_W, 64, width of the cycle and instret counters.
- TIMEOUT, 1024, maximum cycles spent waiting in a single wait state; 0 disables the timeout.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  fetch request accepted.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction.
- dmem_req_valid  out  1  load/store request.
- dmem_req_ready  in  1  load/store request accepted.
- dmem_rsp_valid  in  1  load data valid / store complete.
- dec_mem_read  in  1  decoded from inst_q.
- dec_mem_write  in  1  decoded from inst_q.
- dec_reg_write  in  1  decoded from inst_q.
- dec_ebreak  in  1  decoded from inst_q.
- exu_pc_next  in  XLEN  next PC computed by the EXU.
- pc  out  XLEN  current PC.
- inst_q  out  32  latched instruction.
- rf_wen  out  1  register-file write enable.
- commit_valid  out  1  one-cycle pulse per retired instruction.
- commit_pc  out  XLEN  PC of the retiring instruction.
- commit_pc_next  out  XLEN  next PC of the retiring instruction.
- halted  out  1  sticky; set by ebreak.
- err  out  1  sticky; set by timeout or misalignment.
- cycle_cnt  out  CNT_W  cycle counter.
- instret_cnt  out  CNT_W  retired-instruction counter.

Behaviour:
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERROR.
- Reset (synchronous, active-high, takes effect from any state, including mid-handshake):
  - state=FETCH_REQ, pc=RESET_PC, inst_q=0.
  - Counters=0; halted=0, err=0.
  - All valid/enable/pulse outputs 0.
  - Wait timer cleared.
- FETCH_REQ:
  - imem_req_valid=1, imem_addr=pc.
  - On imem_req_ready -> FETCH_WAIT.
  - Otherwise hold the request stable.
- FETCH_WAIT:
  - imem_rsp_valid is sampled only in this state; a response arrives at earliest the cycle after the request handshake.
  - On rsp_valid: inst_q<=imem_rsp_data -> EXEC.
- EXEC (exactly 1 cycle; dec_* inputs are valid in this state):
  - dec_ebreak -> HALT, taking priority over memory decode. The ebreak retires: commit_valid pulses this cycle, instret increments.
  - Else dec_mem_read|dec_mem_write -> MEM_REQ.
  - Else -> WB.
- MEM_REQ: dmem_req_valid=1 until dmem_req_ready -> MEM_WAIT.
- MEM_WAIT: on dmem_rsp_valid -> WB.
- WB (1 cycle):
  - If exu_pc_next[1:0]!=0 -> ERROR. rf_wen=0, pc unchanged, no commit.
  - Else rf_wen=dec_reg_write, pc<=exu_pc_next, commit_valid=1, commit_pc=pc, commit_pc_next=exu_pc_next, instret+1 -> FETCH_REQ.
- Timeout:
  - The wait timer counts cycles in FETCH_WAIT/MEM_WAIT and clears on each state entry.
  - When it reaches TIMEOUT without a response -> ERROR.
- HALT and ERROR:
  - Both are terminal until rst.
  - No memory requests are issued; responses are ignored.
  - cycle_cnt and instret_cnt freeze.
- cycle_cnt increments every cycle outside HALT/ERROR, including the cycle that enters them. It wraps modulo 2^CNT_W.
- instret_cnt wraps modulo 2^CNT_W.
- Cycle counts with zero-wait memory (ready=1, response 1 cycle after accept):
  - Non-memory instruction: 4 cycles.
  - Load/store: 6 cycles.
- Late imem/dmem responses arriving after reset, or outside the matching wait state, are dropped.

Decomposition:
- Shared package holds:
  - the state enum type;
  - XLEN and RESET_PC defaults;
  - the PC alignment mask constant.
- One sub-module, wait_timeout_timer, with inputs clear/enable, parameter TIMEOUT and output expired. It is instantiated once and shared by both wait states.

Test Plan:
- Reset, then addi at 0x8000_0000 with zero-wait imem, exu_pc_next=0x8000_0004:
  - commit_valid in cycle 4 with commit_pc=0x8000_0000;
  - then pc=0x8000_0004, instret=1, cycle_cnt=4.
- Load with dmem_req_ready delayed 3 cycles and rsp 2 cycles after accept:
  - dmem_req_valid held stable for 4 cycles;
  - rf_wen=1 only in WB;
  - total 10 cycles, instret=1.
- ebreak fetched:
  - commit_valid pulses in EXEC; halted=1 the next cycle;
  - no further imem_req_valid;
  - cycle_cnt/instret frozen for 20 more cycles.
- TIMEOUT=8 with imem never responding: err=1 after 8 FETCH_WAIT cycles, no commit. Repeat with TIMEOUT=0: err stays 0 after 2000 cycles.
- exu_pc_next=0x8000_0006 in WB: err=1, rf_wen=0, pc stays 0x8000_0000, no commit_valid.
- rst asserted during MEM_WAIT, then a dmem_rsp_valid one cycle after rst is released:
  - pc=0x8000_0000, counters=0, state=FETCH_REQ;
  - the late response is ignored.
